// File: rtl/mod0_sample_buffer.sv
// ---------------------------------------------------------------------------
// mod0_sample_buffer
//
// Downstream capture stage for mod0. Every cycle in which mod0 raises its
// strobe (IB1) the 4-bit result on IV1_4 is written into a small FIFO. The
// head of the FIFO is offered to the next consumer over a valid/ready
// handshake. mod0 cannot be stalled, so strobes that arrive while the FIFO
// is full (and nothing drains that cycle) are discarded and counted in a
// saturating drop counter.
//
// Parameters:
//   DEPTH   FIFO entries (power of 2, >= 2)
//   DROP_W  width of the drop counter
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   IV1_4     in   [3:0] sample data from mod0.OV1_3
//   IB1       in   sample strobe from mod0.POB2
//   IB_FLUSH  in   synchronous clear of the queued samples
//   IB_READY  in   downstream ready
//   OV1_4     out  [3:0] head-of-FIFO data (0 when empty)
//   OB_VALID  out  FIFO non-empty
//   OB_FULL   out  occupancy equals DEPTH
//   OV_LEVEL  out  [clog2(DEPTH):0] current occupancy
//   OV_DROP   out  [DROP_W-1:0] saturating count of rejected strobes
// ---------------------------------------------------------------------------
module mod0_sample_buffer #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               IV1_4,
    input  logic                     IB1,
    input  logic                     IB_FLUSH,
    input  logic                     IB_READY,
    output logic [3:0]               OV1_4,
    output logic                     OB_VALID,
    output logic                     OB_FULL,
    output logic [$clog2(DEPTH):0]   OV_LEVEL,
    output logic [DROP_W-1:0]        OV_DROP
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX   = {DROP_W{1'b1}};

    logic [3:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [DROP_W-1:0] drop_cnt;

    logic is_empty;
    logic is_full;
    logic do_pop;
    logic do_push;
    logic do_drop;

    // Transfer decisions. A flush suppresses everything else in its cycle,
    // including the drop bookkeeping. A strobe at full is still accepted
    // when the head leaves in the same cycle, which keeps a full FIFO
    // streaming at one sample per cycle.
    always_comb begin
        is_empty = (level == '0);
        is_full  = (level == FULL_LEVEL);
        do_pop   = !IB_FLUSH && !is_empty && IB_READY;
        do_push  = !IB_FLUSH && IB1 && (!is_full || do_pop);
        do_drop  = !IB_FLUSH && IB1 && is_full && !do_pop;
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (IB_FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (IB_FLUSH) begin
            level <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Drop counter survives a flush; only reset clears it. It sticks at its
    // maximum rather than wrapping so a long overload is never hidden.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (do_drop && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Sample storage is deliberately not reset; the level gates its use.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= IV1_4;
        end
    end

    // Outputs come only from registered state, so there is no
    // combinational path from any input to the consumer side.
    always_comb begin
        OB_VALID = !is_empty;
        OB_FULL  = is_full;
        OV_LEVEL = level;
        OV_DROP  = drop_cnt;
        OV1_4    = is_empty ? 4'h0 : mem[rd_ptr];
    end

endmodule

// File: tb/tb_mod0_sample_buffer.sv
// ---------------------------------------------------------------------------
// tb_mod0_sample_buffer
//
// Drives two buffer instances with identical inputs: one with the default
// 8-bit drop counter and one with a 2-bit counter so saturation is reachable.
// A queue holds the samples the bench expects to be buffered; it is filled
// when an accepted strobe is driven and drained when a pop is due.
// ---------------------------------------------------------------------------
module tb_mod0_sample_buffer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] IV1_4;
    logic       IB1;
    logic       IB_FLUSH;
    logic       IB_READY;

    logic [3:0] ov_data;
    logic       ob_valid;
    logic       ob_full;
    logic [2:0] ov_level;
    logic [7:0] ov_drop;

    logic [3:0] ov_data2;
    logic       ob_valid2;
    logic       ob_full2;
    logic [2:0] ov_level2;
    logic [1:0] ov_drop2;

    logic [3:0] exp_q[$];
    int         exp_drop;
    int         exp_drop2;
    int         checks;
    int         passes;

    mod0_sample_buffer #(.DEPTH(DEPTH), .DROP_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .IV1_4    (IV1_4),
        .IB1      (IB1),
        .IB_FLUSH (IB_FLUSH),
        .IB_READY (IB_READY),
        .OV1_4    (ov_data),
        .OB_VALID (ob_valid),
        .OB_FULL  (ob_full),
        .OV_LEVEL (ov_level),
        .OV_DROP  (ov_drop)
    );

    mod0_sample_buffer #(.DEPTH(DEPTH), .DROP_W(2)) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .IV1_4    (IV1_4),
        .IB1      (IB1),
        .IB_FLUSH (IB_FLUSH),
        .IB_READY (IB_READY),
        .OV1_4    (ov_data2),
        .OB_VALID (ob_valid2),
        .OB_FULL  (ob_full2),
        .OV_LEVEL (ov_level2),
        .OV_DROP  (ov_drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: observed %0h required %0h at %0t",
                     tag, observed, expected, $time);
        end else begin
            passes++;
        end
    endtask

    // All outputs must read zero while reset is asserted.
    task automatic checkResetOutputs();
        checkOutput("rst_data",   32'(ov_data),   32'h0);
        checkOutput("rst_valid",  32'(ob_valid),  32'h0);
        checkOutput("rst_full",   32'(ob_full),   32'h0);
        checkOutput("rst_level",  32'(ov_level),  32'h0);
        checkOutput("rst_drop",   32'(ov_drop),   32'h0);
        checkOutput("rst_drop2",  32'(ov_drop2),  32'h0);
        checkOutput("rst_valid2", 32'(ob_valid2), 32'h0);
    endtask

    // One clock cycle: drive inputs just after the rising edge, check the
    // outputs on the falling edge against the queue, then advance the model
    // with what the coming rising edge should do.
    task automatic applyStimulus(input logic strobe, input logic [3:0] data,
                                 input logic ready, input logic flush);
        int         sz;
        bit         pop_due;
        logic [3:0] head;
        IB1      = strobe;
        IV1_4    = data;
        IB_READY = ready;
        IB_FLUSH = flush;
        @(negedge clk);
        sz   = exp_q.size();
        head = (sz != 0) ? exp_q[0] : 4'h0;
        checkOutput("valid",  32'(ob_valid),  32'(sz != 0));
        checkOutput("full",   32'(ob_full),   32'(sz == DEPTH));
        checkOutput("level",  32'(ov_level),  32'(sz));
        checkOutput("head",   32'(ov_data),   32'(head));
        checkOutput("drop",   32'(ov_drop),   32'(exp_drop));
        checkOutput("head2",  32'(ov_data2),  32'(head));
        checkOutput("drop2",  32'(ov_drop2),  32'(exp_drop2));
        if (flush) begin
            exp_q.delete();
        end else begin
            pop_due = (sz != 0) && ready;
            if (pop_due) begin
                void'(exp_q.pop_front());
            end
            if (strobe) begin
                if (sz < DEPTH || pop_due) begin
                    exp_q.push_back(data);
                end else begin
                    if (exp_drop < 255) exp_drop++;
                    if (exp_drop2 < 3) exp_drop2++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        exp_drop  = 0;
        exp_drop2 = 0;
        rst_n     = 1'b0;
        IB1       = 1'b0;
        IV1_4     = 4'h0;
        IB_FLUSH  = 1'b0;
        IB_READY  = 1'b0;

        // Power-on reset.
        #1;
        checkResetOutputs();
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Some traffic, then reset mid-stream with samples queued.
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hB, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs();
        exp_q.delete();
        exp_drop  = 0;
        exp_drop2 = 0;
        @(posedge clk);
        #1;
        checkResetOutputs();
        IB1 = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic ordering: 3, 9, F queued, then drained.
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);

        // Overflow: six strobes into four slots.
        for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);

        // Drop saturation: five more strobes while held full.
        for (int i = 8; i <= 12; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

        // Push and pop together while full, then drain: 2, 3, 4, 7.
        applyStimulus(1'b1, 4'h7, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);

        // Flush with a concurrent strobe and ready.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'(i + 5), 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hE, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

        // Continuous push/pop across pointer wrap.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'(i + 3), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
